draw_sequencer: RTL and testbench

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

---
 rtl/draw_sequencer.sv | 141 ++++++++++++++
 tb/tb_draw_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_sequencer.sv
// Frame sequencer: clears the screen, then hands the VGA port to each sprite
// client in turn (enable pulse, pixel pass-through, done or timeout), then ends the frame.
module draw_sequencer #(
  parameter int         N_CLIENTS    = 3,
  parameter int         SCREEN_W     = 320,
  parameter int         SCREEN_H     = 240,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000,
  parameter int         TIMEOUT      = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  output logic [N_CLIENTS-1:0]   client_enable,
  input  logic [N_CLIENTS-1:0]   client_done,
  input  logic [N_CLIENTS-1:0]   client_plot,
  input  logic [9*N_CLIENTS-1:0] client_x,
  input  logic [8*N_CLIENTS-1:0] client_y,
  input  logic [3*N_CLIENTS-1:0] client_colour,
  output logic [8:0]             vga_x,
  output logic [7:0]             vga_y,
  output logic [2:0]             vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun,
  output logic                   timeout_err
);

  localparam int SEL_W = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int TO_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, ENABLE, WAIT_DONE, FINISH} state_t;
  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       plot;
  } pix_t;

  state_t          state, nstate;
  logic [8:0]      x_cnt;
  logic [7:0]      y_cnt;
  logic [TO_W-1:0] tcnt;
  logic [SEL_W-1:0] sel;
  pix_t            cap;
  pix_t            cl [N_CLIENTS];

  for (genvar g = 0; g < N_CLIENTS; g++) begin : g_unpack
    assign cl[g].x      = client_x[9*g +: 9];
    assign cl[g].y      = client_y[8*g +: 8];
    assign cl[g].colour = client_colour[3*g +: 3];
    assign cl[g].plot   = client_plot[g];
  end

  logic last_px, last_cl, sel_done, tmo;
  assign last_px  = (x_cnt == 9'(SCREEN_W - 1)) && (y_cnt == 8'(SCREEN_H - 1));
  assign last_cl  = (sel == SEL_W'(N_CLIENTS - 1));
  assign sel_done = client_done[sel];
  // tcnt counts completed wait cycles, so WAIT_DONE lasts at most TIMEOUT cycles
  assign tmo      = (tcnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:      if (frame_tick) nstate = CLEAR;
      CLEAR:     if (last_px) nstate = ENABLE;
      ENABLE:    nstate = WAIT_DONE;
      WAIT_DONE: if (sel_done || tmo) nstate = last_cl ? FINISH : ENABLE;
      FINISH:    nstate = IDLE;
      default:   nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_cnt       <= '0;
      y_cnt       <= '0;
      tcnt        <= '0;
      sel         <= '0;
      cap         <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (frame_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (frame_tick) begin
          x_cnt <= '0;
          y_cnt <= '0;
          sel   <= '0;
        end
        CLEAR: begin
          cap <= '{x: x_cnt, y: y_cnt, colour: CLEAR_COLOUR, plot: 1'b0};
          if (x_cnt == 9'(SCREEN_W - 1)) begin
            x_cnt <= '0;
            y_cnt <= last_px ? '0 : y_cnt + 8'd1;
          end else begin
            x_cnt <= x_cnt + 9'd1;
          end
        end
        ENABLE: begin
          tcnt     <= '0;
          cap.plot <= 1'b0;
        end
        WAIT_DONE: begin
          tcnt <= tcnt + TO_W'(1);
          cap  <= cl[sel];
          if (!sel_done && tmo) timeout_err <= 1'b1;
          if ((sel_done || tmo) && !last_cl) sel <= sel + SEL_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    client_enable = '0;
    busy          = (state != IDLE);
    frame_done    = (state == FINISH);
    vga_x         = cap.x;
    vga_y         = cap.y;
    vga_colour    = cap.colour;
    vga_plot      = 1'b0;
    case (state)
      CLEAR: begin
        vga_x      = x_cnt;
        vga_y      = y_cnt;
        vga_colour = CLEAR_COLOUR;
        vga_plot   = 1'b1;
      end
      ENABLE:    client_enable[sel] = 1'b1;
      WAIT_DONE: vga_plot = cap.plot;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: randomized client responders plus an observed-behaviour
// model of a frame (raster clear, enable order and spacing, one-cycle pixel pass-through).
module tb_draw_sequencer;
  localparam int         N  = 3;
  localparam int         W  = 20;
  localparam int         H  = 6;
  localparam int         TO = 63;
  localparam logic [2:0] CC = 3'b110;

  logic           clk = 1'b0, reset = 1'b1, frame_tick = 1'b0;
  logic [N-1:0]   client_enable, client_done, client_plot;
  logic [9*N-1:0] client_x;
  logic [8*N-1:0] client_y;
  logic [3*N-1:0] client_colour;
  logic [8:0]     vga_x;
  logic [7:0]     vga_y;
  logic [2:0]     vga_colour;
  logic           vga_plot, busy, frame_done, overrun, timeout_err;

  draw_sequencer #(.N_CLIENTS(N), .SCREEN_W(W), .SCREEN_H(H), .CLEAR_COLOUR(CC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .client_enable(client_enable),
    .client_done(client_done), .client_plot(client_plot), .client_x(client_x), .client_y(client_y),
    .client_colour(client_colour), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .frame_done(frame_done), .overrun(overrun),
    .timeout_err(timeout_err));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // responder configuration, written only by the main sequence
  int delay [N];
  bit never [N];
  bit glitch = 1'b0;

  // clients: answer done `delay` cycles after their enable, stream random pixels
  initial begin
    int cnt [N];
    bit armed [N];
    for (int i = 0; i < N; i++) begin armed[i] = 1'b0; cnt[i] = 0; end
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        client_done[i] = 1'b0;
        if (reset) armed[i] = 1'b0;
        else begin
          if (armed[i]) begin
            if (cnt[i] == 1) begin armed[i] = 1'b0; client_done[i] = !never[i]; end
            cnt[i]--;
          end
          if (client_enable[i]) begin armed[i] = 1'b1; cnt[i] = delay[i]; end
        end
        client_plot[i]          = 1'($urandom);
        client_x[9*i +: 9]      = 9'($urandom);
        client_y[8*i +: 8]      = 8'($urandom);
        client_colour[3*i +: 3] = 3'($urandom);
      end
      if (glitch && armed[0] && cnt[0] == delay[0] - 3) client_done[2] = 1'b1;
    end
  end

  // observer state, written only by the monitor
  int cyc = 0, frames = 0, tick_cyc = 0, fd_cyc = 0, fd_cnt = 0, idle_plot = 0;
  int clr_cycles = 0, clr_ok = 0, rx = 0, ry = 0, en_bad = 0, pix_bad = 0, pix_checks = 0;
  int en_idx[$], en_cyc[$];
  int wsel = 0;
  bit busy_q = 1'b0, in_win = 1'b0, first = 1'b0, pp = 1'b0;
  logic [8:0] px;
  logic [7:0] py;
  logic [2:0] pc;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (frame_tick && !busy) tick_cyc = cyc;
      if (busy && !busy_q) begin
        frames++;
        rx = 0; ry = 0; clr_cycles = 0; clr_ok = 0; en_bad = 0; fd_cnt = 0;
        pix_bad = 0; pix_checks = 0; in_win = 1'b0;
        en_idx.delete(); en_cyc.delete();
      end
      if (!busy) begin
        in_win = 1'b0;
        if (vga_plot) idle_plot++;
      end else if (en_idx.size() == 0 && client_enable == '0) begin
        // clear phase: one raster pixel per cycle
        clr_cycles++;
        if (vga_plot && vga_colour == CC && vga_x == 9'(rx) && vga_y == 8'(ry)) begin
          clr_ok++;
          rx++;
          if (rx == W) begin rx = 0; ry++; end
        end
      end
      if (client_enable != '0 || frame_done) begin
        if (vga_plot) pix_bad++;
        if (client_enable != '0) begin
          if ($countones(client_enable) != 1) en_bad++;
          wsel = $clog2(client_enable);
          en_idx.push_back(wsel);
          en_cyc.push_back(cyc);
          in_win = 1'b1;
          first  = 1'b1;
        end else begin
          fd_cnt++;
          fd_cyc = cyc;
          in_win = 1'b0;
        end
      end else if (in_win) begin
        // selected client's pixel from the previous cycle must appear now
        pix_checks++;
        if (first) begin
          if (vga_plot) pix_bad++;
        end else if (vga_plot !== pp || (pp && {vga_x, vga_y, vga_colour} !== {px, py, pc}))
          pix_bad++;
        first = 1'b0;
      end
      if (in_win) begin
        pp = client_plot[wsel];
        px = client_x[9*wsel +: 9];
        py = client_y[8*wsel +: 8];
        pc = client_colour[3*wsel +: 3];
      end
      busy_q = busy;
    end
  end

  task automatic pulse_tick();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic run_frame(input string tag, input bit ovr_tick);
    bit seen;
    pulse_tick();
    repeat (2) @(negedge clk);
    if (ovr_tick) begin
      repeat (30) @(posedge clk);
      #1 frame_tick = 1'b1;
      @(posedge clk); #1 frame_tick = 1'b0;
    end
    seen = 1'b0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      seen = (fd_cnt > 0);
    end
    if (!seen) chk({tag, "_frame_end_bound"}, 0, 1);
    repeat (5) @(posedge clk);
  endtask

  task automatic rand_delays();
    for (int i = 0; i < N; i++) begin
      delay[i] = $urandom_range(5, 40);
      never[i] = 1'b0;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk(tag, {4'd0, vga_x, vga_y, vga_colour, vga_plot, client_enable, busy, frame_done,
              overrun, timeout_err}, 32'd0);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_clr_cycles"}, clr_cycles, W*H);
    chk({tag, "_clr_raster"}, clr_ok, W*H);
    chk({tag, "_en_count"}, en_idx.size(), N);
    if (en_idx.size() == N) begin
      chk({tag, "_en_order"}, en_idx[0]*100 + en_idx[1]*10 + en_idx[2], 12);
      chk({tag, "_tick_to_en0"}, en_cyc[0] - tick_cyc, W*H + 1);
      chk({tag, "_en0_to_en1"}, en_cyc[1] - en_cyc[0], delay[0] + 1);
      chk({tag, "_en1_to_en2"}, en_cyc[2] - en_cyc[1], never[1] ? TO + 1 : delay[1] + 1);
      chk({tag, "_en2_to_fd"}, fd_cyc - en_cyc[2], delay[2] + 1);
    end
    chk({tag, "_en_onehot"}, en_bad, 0);
    chk({tag, "_fd_count"}, fd_cnt, 1);
    chk({tag, "_pix_bad"}, pix_bad, 0);
    chk({tag, "_pix_checked"}, pix_checks > 0, 1);
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int f0, ip0;
    bit seen;
    for (int i = 0; i < N; i++) begin delay[i] = 10; never[i] = 1'b0; end
    repeat (3) @(posedge clk);
    #1 check_outputs_zero("reset_state");
    reset = 1'b0;
    repeat (3) @(posedge clk);
    check_outputs_zero("idle_after_reset");

    // normal frame with a stray done[2] during client 0 and an overrun tick mid-clear
    rand_delays();
    glitch = 1'b1;
    f0 = frames; ip0 = idle_plot;
    run_frame("frameA", 1'b1);
    glitch = 1'b0;
    check_frame("frameA");
    chk("frameA_overrun", overrun, 1);
    chk("frameA_timeout_err", timeout_err, 0);
    repeat (30) @(posedge clk);
    chk("frameA_single_frame", frames - f0, 1);
    chk("frameA_idle_plots", idle_plot - ip0, 0);
    chk("frameA_overrun_sticky", overrun, 1);

    // client 1 never answers
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("frameB_sticky_cleared", {overrun, timeout_err}, 0);
    rand_delays();
    never[1] = 1'b1;
    run_frame("frameB", 1'b0);
    check_frame("frameB");
    chk("frameB_timeout_err", timeout_err, 1);
    chk("frameB_overrun", overrun, 0);

    // reset while client 0 is being waited on
    rand_delays();
    delay[0] = 50;
    pulse_tick();
    seen = 1'b0;
    for (int k = 0; k < 500 && !seen; k++) begin
      @(negedge clk);
      seen = (en_idx.size() > 0);
    end
    if (!seen) chk("abort_en0_bound", 0, 1);
    repeat (10) @(negedge clk);
    chk("abort_in_wait", busy, 1);
    #2 reset = 1'b1;
    #1 check_outputs_zero("abort_async_reset");
    @(posedge clk); #1 reset = 1'b0;
    repeat (20) @(posedge clk);
    chk("abort_no_frame_done", fd_cnt, 0);
    chk("abort_idle", busy, 0);

    // fresh frame after the abort restarts at (0,0)
    rand_delays();
    run_frame("frameD", 1'b0);
    check_frame("frameD");
    chk("frameD_flags", {overrun, timeout_err}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: observed timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
